// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Holds the FSM state encoding, the baud divider rule and the sample points.
// No logic; only types, constants and a constant function.
package uart_pkg;

  // Frame FSM states (2-bit encoding shared with the TX side)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Ticks per bit; the tick counters below are sized for exactly this
  localparam int unsigned OVERSAMPLE_RATE = 16;

  // Tick index of the middle of the start bit, and of each later bit
  // (counted from the previous sample point, so one full bit later)
  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_END = 4'd15;

  // Clocks per oversample tick, truncating
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE_RATE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: emits a one-clk tick every CLK_FREQ/(BAUD*16) clocks.
// Latency: first tick DIV clocks after clr drops; clr holds the phase at 0.
// Backpressure: none; free-running while clr is low.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider counter: 0..DIV-1, forced to 0 while clr so ticks align to clr release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = !clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, mid-bit sampling, LSB first.
// Latency: rx_done about 9.5 bit periods + 3 clk after the start-bit falling edge.
// Backpressure: none; no FIFO, the next good frame overwrites rx_data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  // The tick/bit counters are hard-sized for 16 samples per bit
  if (OVERSAMPLE != OVERSAMPLE_RATE) begin : g_bad_oversample
    $error("uart_rx: only OVERSAMPLE=16 is supported");
  end

  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_d;
  uart_state_t r_state;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_busy;
  logic        r_ferr;

  logic        w_fall;
  logic        w_tick;
  logic        w_tick_clr;

  // Two-flop synchronizer plus a delay flop for edge detection; idle-high reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // Only a high-to-low transition starts a frame, so a held-low line never retriggers
  assign w_fall     = r_rx_d && !r_rx_s;
  assign w_tick_clr = (r_state == IDLE);

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_tick_clr),
    .tick  (w_tick)
  );

  // Frame FSM: start-bit validation, data shift, stop check and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == SAMPLE_MID) begin
              r_tick_cnt <= '0;
              if (!r_rx_s) begin
                r_ferr  <= 1'b0;
                r_state <= DATA;
              end else begin
                // Line went back high before mid start bit: glitch, drop it
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == SAMPLE_END) begin
              r_shift   <= {r_rx_s, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == SAMPLE_END) begin
              if (r_rx_s) begin
                r_data <= r_shift;
                r_done <= 1'b1;
              end else begin
                r_ferr <= 1'b1;
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing `uart` transmitter.
- Oversamples the serial line at 16x baud, validates the start bit, samples data bits mid-bit, LSB first, and checks the stop bit.
- Presents each received byte on `rx_data` with a one-clock `rx_done` strobe, for a downstream ASCII consumer (echo/display logic).

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last correctly framed byte.
- rx_done  output  1  one-clk pulse; rx_data is valid in the same cycle.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  stop bit was sampled low; held until cleared.

Behaviour:
- Reset is asynchronous and active-low. Values while reset is low:
  - rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0.
  - State=IDLE, all counters=0.
  - Both synchronizer flops=1.
- Synchronizer: rx passes through 2 flops (rx_s). A third flop rx_d detects falling edges; it resets to 1.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; 651 at the defaults.
  - Counts 0..DIV-1 and emits a 1-clk tick on DIV-1.
  - Held at 0 in IDLE, so tick phase aligns to the start edge.
- tick_cnt (4 bits) counts ticks within a bit. bit_cnt (3 bits) counts data bits.
- IDLE:
  - Enter START on a falling edge (rx_d=1, rx_s=0). A low level alone does not trigger, so a line held low (break) does not retrigger.
- START:
  - On the tick where tick_cnt==7 (mid start bit), check rx_s.
  - rx_s=0: clear frame_err, clear tick_cnt, go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE with no outputs changed.
- DATA:
  - On each tick where tick_cnt==15, shift rx_s into shift_reg[7] (right shift, LSB first) and increment bit_cnt.
  - After the 8th sample, with bit_cnt wrapping 7->0, go to STOP.
- STOP:
  - On the tick where tick_cnt==15, check rx_s.
  - rx_s=1: rx_data<=shift_reg, rx_done=1 for exactly one clk.
  - rx_s=0: frame_err<=1, rx_data unchanged, no rx_done.
  - In both cases go to IDLE the next clk.
- Latency: rx_done rises about 9.5 bit periods plus 3 clk after the start-bit falling edge on rx. At the defaults this is 152*651 + 3 clk, ±1 clk.
- Back-to-back frames:
  - The stop sample lands mid stop bit, so IDLE is re-entered about 0.5 bit before the next start edge.
  - A start edge arriving in the same clk as the STOP→IDLE transition is not required to be caught.
- Reset mid-frame: the partial frame is discarded, outputs return to reset values, and the receiver resumes in IDLE.
- There is no receive FIFO. The consumer must take rx_data before the next rx_done; the next good frame overwrites it.

Decomposition:
- Shared package `uart_pkg` holds:
  - state encoding IDLE/START/DATA/STOP (2-bit localparams);
  - DIV computation;
  - the sample-point constants 7 and 15.
- The transmitter reuses the same package.
- One sub-module, `baud_tick_gen` (parameters CLK_FREQ, BAUD; ports clk, reset, clr, tick), shared with the TX side.
- FSM, shift register and synchronizer stay in `uart_rx`.

Test Plan:
- Drive 8N1 frame 0x41 at 9600 baud (bit = 10416 clk) → one rx_done pulse; rx_data=8'h41; frame_err=0; rx_busy high only during the frame.
- Back-to-back frames 0x00, 0xFF, 0x55, 0xAA with a single stop bit → four rx_done pulses with matching rx_data, none missed.
- rx low pulse of 3000 clk (shorter than half a bit), then idle → no rx_done, rx_busy returns to 0, rx_data unchanged.
- Frame 0x3C with stop bit driven 0, then line held low 5 bit times, then valid frame 0x7E:
  - frame_err=1 with no rx_done during the bad frame;
  - no retrigger while the line is held low;
  - 0x7E received, with frame_err cleared at its start-bit check.
- Assert reset (low) during bit 4 of a 0xA5 frame, release, then send 0x5A → all outputs at reset values during reset; exactly one rx_done with rx_data=8'h5A.
- Parameter check, CLK_FREQ=50_000_000 and BAUD=115200 (DIV=27) → frame 0xC3 received correctly.
